aes_req_arbiter: RTL and testbench
==================================

AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set the maximum number of WAIT cycles allowed for core_done before an error response is issued.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req0, req1  input  1 each  requester i asks for one AES operation; held until gnt_i.
REQ-005 data0, data1  input  128 each  plaintext of requester i, sampled at acceptance.
REQ-006 key0, key1  input  256 each  key of requester i, MSB-aligned; 128/192-bit keys occupy the upper bits.
REQ-007 mode0, mode1  input  2 each  key size of requester i: 1=AES-128, 2=AES-192, 3=AES-256, 0=illegal.
REQ-008 gnt0, gnt1  output  1 each  one-cycle acceptance pulse to requester i.
REQ-009 core_start  output  1  one-cycle start pulse to the shared AES core.
REQ-010 core_in, core_key, core_mode  output  128/256/2  registered operands to the core.
REQ-011 core_done, core_out  input  1/128  core completion pulse and ciphertext.
REQ-012 rsp_valid0, rsp_valid1  output  1 each  response available for requester i.
REQ-013 rsp_ready0, rsp_ready1  input  1 each  requester i consumes the response.
REQ-014 rsp_data, rsp_err  output  128/1  shared response ciphertext and error flag.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT and RESP, one transaction at a time.
REQ-016 IDLE: when any req is high at edge N, the winner SHALL be chosen round-robin (the requester other than last_winner wins a tie), its data/key/mode latched, and the state SHALL become ISSUE at N+1.
REQ-017 A single requesting channel SHALL win regardless of last_winner.
REQ-018 ISSUE (exactly 1 cycle): gnt_winner=1; core_start=1 only if the latched mode!=0; next state WAIT if mode!=0, else RESP with rsp_err=1 and rsp_data=0.
REQ-019 core_in, core_key and core_mode SHALL hold the latched operands, constant from ISSUE until the next acceptance.
REQ-020 WAIT: an 8-bit wait counter SHALL clear on entry and increment each cycle.
REQ-021 WAIT: on core_done=1, core_out SHALL be captured into rsp_data, rsp_err=0, and the next state SHALL be RESP.
REQ-022 WAIT: when the counter reaches TIMEOUT-1 without core_done, the next state SHALL be RESP with rsp_err=1 and rsp_data=0.
REQ-023 If core_done and the timeout occur in the same cycle, core_done SHALL win (no error).
REQ-024 core_done outside WAIT SHALL be ignored with no state change.
REQ-025 RESP: rsp_valid_winner SHALL be held at 1, the other rsp_valid at 0, and rsp_data/rsp_err held stable until rsp_ready_winner=1.
REQ-026 RESP: on rsp_ready_winner, last_winner SHALL update to the winner and the state SHALL return to IDLE on the next cycle.
REQ-027 rsp_ready of the non-owner SHALL be ignored.
REQ-028 Minimum latency: req at N, gnt/core_start at N+1, core_done at N+1+L gives rsp_valid at N+2+L.
REQ-029 Requests arriving while busy SHALL wait; no request SHALL be lost or granted twice.

Reset
REQ-030 On reset low, state SHALL be IDLE immediately (asynchronously) and outputs SHALL be: gnt*, core_start, rsp_valid*, rsp_err = 0; core_in, core_key, core_mode, rsp_data = 0; counter = 0; last_winner = 1.
REQ-031 Reset asserted mid-transaction SHALL abort it with no response; after release the arbiter SHALL accept new requests normally.

Verification
REQ-032 req0 alone, mode0=1, data=00112233445566778899aabbccddeeff, key=000102...0f, core_done after 10 cycles with core_out=69c4e0d86a7b0430d8cdb78070b4c55a -> gnt0 at N+1, rsp_valid0 with that data and rsp_err=0.
REQ-033 req0 and req1 high together from reset -> req0 granted first, then req1; with both held, grants alternate 0,1,0,1.
REQ-034 mode1=0 -> gnt1 pulse, no core_start, rsp_valid1 with rsp_err=1 and rsp_data=0.
REQ-035 core_done never asserted, TIMEOUT=64 -> rsp_err=1 exactly 64 WAIT cycles after entry; core_done coincident with the last cycle -> rsp_err=0.
REQ-036 rsp_ready held low for 20 cycles -> rsp_valid and rsp_data stable for all 20; a spurious core_done pulse in RESP changes nothing.
REQ-037 Reset pulsed during WAIT -> all outputs 0 immediately; a fresh req1 afterwards completes normally.

Source files
------------

// File: rtl/aes_req_arbiter.sv
// rtl/aes_req_arbiter.sv - two-requester round-robin front end for a shared AES core
//
// Purpose: accepts one AES request at a time from two requesters, issues it to
// the shared core, waits (bounded by TIMEOUT) for completion and hands the
// ciphertext or an error back to the requester that won arbitration.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0/1, data0/1, key0/1,   request, plaintext, MSB-aligned key and key size
//   mode0/1                    (1=128, 2=192, 3=256, 0=illegal) per requester
//   gnt0/1                     one-cycle acceptance pulse per requester
//   core_start                 one-cycle start pulse to the core
//   core_in, core_key,         latched operands driven to the core
//   core_mode
//   core_done, core_out        core completion pulse and ciphertext
//   rsp_valid0/1, rsp_ready0/1 per-requester response handshake
//   rsp_data, rsp_err          shared response payload and error flag

module aes_req_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic [127:0] data0,
    input  logic [127:0] data1,
    input  logic [255:0] key0,
    input  logic [255:0] key1,
    input  logic [1:0]   mode0,
    input  logic [1:0]   mode1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         core_start,
    output logic [127:0] core_in,
    output logic [255:0] core_key,
    output logic [1:0]   core_mode,
    input  logic         core_done,
    input  logic [127:0] core_out,
    output logic         rsp_valid0,
    output logic         rsp_valid1,
    input  logic         rsp_ready0,
    input  logic         rsp_ready1,
    output logic [127:0] rsp_data,
    output logic         rsp_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Counter value on the last permitted WAIT cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       winner;
    logic       last_winner;
    logic [7:0] wait_cnt;
    logic       pick;
    logic       owner_ready;
    logic       wait_expired;

    // Round robin: on a tie the requester that did not win last time goes first;
    // a lone requester always wins.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_winner;
        end else begin
            pick = req1;
        end
    end

    assign owner_ready  = winner ? rsp_ready1 : rsp_ready0;
    assign wait_expired = (wait_cnt == WAIT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; core_done beats the timeout when both land together.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (req0 || req1) state_nxt = ISSUE;
            ISSUE: state_nxt = (core_mode != 2'd0) ? WAIT : RESP;
            WAIT:  if (core_done || wait_expired) state_nxt = RESP;
            RESP:  if (owner_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state and the latched owner
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        core_start = 1'b0;
        rsp_valid0 = 1'b0;
        rsp_valid1 = 1'b0;
        if (state == ISSUE) begin
            gnt0       = ~winner;
            gnt1       = winner;
            core_start = (core_mode != 2'd0);
        end
        if (state == RESP) begin
            rsp_valid0 = ~winner;
            rsp_valid1 = winner;
        end
    end

    // Datapath: operand latch, wait counter, response capture, fairness pointer.
    // Operands stay on core_* until the next acceptance so the core may sample late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner      <= 1'b0;
            last_winner <= 1'b1;
            wait_cnt    <= 8'd0;
            core_in     <= 128'd0;
            core_key    <= 256'd0;
            core_mode   <= 2'd0;
            rsp_data    <= 128'd0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        winner    <= pick;
                        core_in   <= pick ? data1 : data0;
                        core_key  <= pick ? key1  : key0;
                        core_mode <= pick ? mode1 : mode0;
                    end
                end
                ISSUE: begin
                    wait_cnt <= 8'd0;
                    if (core_mode == 2'd0) begin
                        rsp_data <= 128'd0;
                        rsp_err  <= 1'b1;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (core_done) begin
                        rsp_data <= core_out;
                        rsp_err  <= 1'b0;
                    end else if (wait_expired) begin
                        rsp_data <= 128'd0;
                        rsp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    if (owner_ready) begin
                        last_winner <= winner;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb/tb_aes_req_arbiter.sv - self-checking bench for aes_req_arbiter

module tb_aes_req_arbiter;

    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 0, req1 = 0;
    logic [127:0] data0 = '0, data1 = '0;
    logic [255:0] key0 = '0, key1 = '0;
    logic [1:0]   mode0 = '0, mode1 = '0;
    logic         gnt0, gnt1, core_start;
    logic [127:0] core_in;
    logic [255:0] core_key;
    logic [1:0]   core_mode;
    logic         core_done = 0;
    logic [127:0] core_out = '0;
    logic         rsp_valid0, rsp_valid1;
    logic         rsp_ready0 = 0, rsp_ready1 = 0;
    logic [127:0] rsp_data;
    logic         rsp_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes_req_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .key0(key0), .key1(key1), .mode0(mode0), .mode1(mode1),
        .gnt0(gnt0), .gnt1(gnt1), .core_start(core_start),
        .core_in(core_in), .core_key(core_key), .core_mode(core_mode),
        .core_done(core_done), .core_out(core_out),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    // Observations of one transaction, filled in by serve()
    int           o_gnt_id, o_gnt_cyc, o_gnt_cnt, o_start_cnt;
    int           o_rsp_id, o_rsp_cyc, o_unstable, o_hold_seen;
    logic [127:0] o_core_in, o_rsp_data;
    logic [255:0] o_core_key;
    logic [1:0]   o_core_mode;
    logic         o_rsp_err, o_valid_after;

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [255:0] rand256();
        return {rand128(), rand128()};
    endfunction

    // Plays the core and the requesters for one transaction. Cycle 1 is the first
    // negedge after the call. The core pulses core_done dly cycles after the grant
    // (dly=0: never). The owner holds rsp_ready low for `hold` response cycles while
    // the other requester drives its ready high; spur injects core_done during RESP.
    task automatic serve(input int dly, input logic [127:0] cout, input int hold,
                         input bit spur, input bit keep);
        int cyc, st, hc;
        bit ack, fin;
        o_gnt_id = -1; o_gnt_cyc = -1; o_gnt_cnt = 0; o_start_cnt = 0;
        o_rsp_id = -1; o_rsp_cyc = -1; o_unstable = 0; o_hold_seen = 0;
        o_valid_after = 1'bx; o_rsp_err = 1'bx; o_rsp_data = 'x;
        cyc = 0; st = -1; hc = 0; ack = 0; fin = 0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            core_done = 0;
            if (ack) begin
                o_valid_after = rsp_valid0 | rsp_valid1;
                rsp_ready0 = 0; rsp_ready1 = 0; fin = 1;
            end else begin
                if (gnt0 || gnt1) begin
                    o_gnt_cnt++;
                    o_gnt_id = gnt1 ? 1 : 0; o_gnt_cyc = cyc; st = cyc;
                    o_core_in = core_in; o_core_key = core_key; o_core_mode = core_mode;
                    if (!keep) begin
                        if (gnt0) req0 = 0;
                        if (gnt1) req1 = 0;
                    end
                end
                if (core_start) o_start_cnt++;
                if (rsp_valid0 || rsp_valid1) begin
                    if (o_rsp_id < 0) begin
                        o_rsp_id = rsp_valid1 ? 1 : 0; o_rsp_cyc = cyc;
                        o_rsp_data = rsp_data; o_rsp_err = rsp_err;
                    end else if (rsp_data !== o_rsp_data || rsp_err !== o_rsp_err ||
                                 rsp_valid0 !== (o_rsp_id == 0) || rsp_valid1 !== (o_rsp_id == 1)) begin
                        o_unstable++;
                    end
                    if (hc < hold) begin
                        o_hold_seen++;
                        rsp_ready0 = (o_rsp_id == 1); rsp_ready1 = (o_rsp_id == 0);
                        if (spur && hc == 0) begin core_done = 1; core_out = ~cout; end
                        hc++;
                    end else begin
                        rsp_ready0 = (o_rsp_id == 0); rsp_ready1 = (o_rsp_id == 1);
                        ack = 1;
                    end
                end else if (st >= 0 && dly > 0 && cyc == st + dly) begin
                    core_done = 1; core_out = cout;
                end
            end
        end
        rsp_ready0 = 0; rsp_ready1 = 0; core_done = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if ({gnt0, gnt1, core_start, rsp_valid0, rsp_valid1, rsp_err} !== 6'b0) begin failures++; $display("FAIL reset_ctrl got=%b want=000000", {gnt0, gnt1, core_start, rsp_valid0, rsp_valid1, rsp_err}); end
        checks++; if (core_in !== '0 || core_key !== '0 || core_mode !== '0) begin failures++; $display("FAIL reset_operands in=%h mode=%0d want 0", core_in, core_mode); end
        checks++; if (rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_vector();
        logic [127:0] ct;
        ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        data0 = 128'h00112233445566778899aabbccddeeff;
        key0  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        mode0 = 2'd1; req0 = 1;
        serve(10, ct, 0, 0, 0);
        checks++; if (o_gnt_id !== 0 || o_gnt_cyc !== 1) begin failures++; $display("FAIL vec_gnt id=%0d cyc=%0d want id=0 cyc=1", o_gnt_id, o_gnt_cyc); end
        checks++; if (o_start_cnt !== 1) begin failures++; $display("FAIL vec_start got=%0d want=1", o_start_cnt); end
        checks++; if (o_core_in !== data0 || o_core_key !== key0 || o_core_mode !== 2'd1) begin failures++; $display("FAIL vec_operands in=%h mode=%0d", o_core_in, o_core_mode); end
        checks++; if (o_rsp_id !== 0 || o_rsp_cyc !== 12) begin failures++; $display("FAIL vec_rsp id=%0d cyc=%0d want id=0 cyc=12", o_rsp_id, o_rsp_cyc); end
        checks++; if (o_rsp_data !== ct || o_rsp_err !== 1'b0) begin failures++; $display("FAIL vec_rsp_data got=%h err=%b want=%h err=0", o_rsp_data, o_rsp_err, ct); end
        checks++; if (o_valid_after !== 1'b0) begin failures++; $display("FAIL vec_release got=%b want=0", o_valid_after); end
    endtask

    task automatic test_rr_alternate();
        @(negedge clk) rst_n = 0;
        @(negedge clk) rst_n = 1;
        data0 = rand128(); data1 = rand128(); mode0 = 2'd2; mode1 = 2'd3;
        req0 = 1; req1 = 1;
        for (int i = 0; i < 4; i++) begin
            serve(3, rand128(), 0, 0, 1);
            checks++; if (o_gnt_id !== (i % 2) || o_gnt_cyc !== 1 || o_gnt_cnt !== 1) begin failures++; $display("FAIL rr_order[%0d] id=%0d cyc=%0d n=%0d want id=%0d", i, o_gnt_id, o_gnt_cyc, o_gnt_cnt, i % 2); end
            checks++; if (o_core_in !== ((i % 2) ? data1 : data0)) begin failures++; $display("FAIL rr_data[%0d] got=%h", i, o_core_in); end
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_illegal_mode();
        data1 = rand128(); key1 = rand256(); mode1 = 2'd0; req1 = 1;
        serve(0, '0, 0, 0, 0);
        checks++; if (o_gnt_id !== 1 || o_gnt_cyc !== 1) begin failures++; $display("FAIL ill_gnt id=%0d cyc=%0d want id=1 cyc=1", o_gnt_id, o_gnt_cyc); end
        checks++; if (o_start_cnt !== 0) begin failures++; $display("FAIL ill_start got=%0d want=0", o_start_cnt); end
        checks++; if (o_rsp_id !== 1 || o_rsp_cyc !== 2 || o_rsp_err !== 1'b1 || o_rsp_data !== '0) begin failures++; $display("FAIL ill_rsp id=%0d cyc=%0d err=%b data=%h want id=1 cyc=2 err=1 data=0", o_rsp_id, o_rsp_cyc, o_rsp_err, o_rsp_data); end
    endtask

    task automatic test_timeout();
        logic [127:0] ct;
        data0 = rand128(); mode0 = 2'd3; req0 = 1;
        serve(0, '0, 0, 0, 0);
        checks++; if (o_rsp_cyc !== TO + 2 || o_rsp_err !== 1'b1 || o_rsp_data !== '0) begin failures++; $display("FAIL timeout cyc=%0d err=%b data=%h want cyc=%0d err=1 data=0", o_rsp_cyc, o_rsp_err, o_rsp_data, TO + 2); end
        ct = rand128(); req0 = 1;
        serve(TO, ct, 0, 0, 0);
        checks++; if (o_rsp_cyc !== TO + 2 || o_rsp_err !== 1'b0 || o_rsp_data !== ct) begin failures++; $display("FAIL done_at_limit cyc=%0d err=%b data=%h want cyc=%0d err=0 data=%h", o_rsp_cyc, o_rsp_err, o_rsp_data, TO + 2, ct); end
    endtask

    task automatic test_hold();
        logic [127:0] ct;
        ct = rand128(); data1 = rand128(); mode1 = 2'd1; req1 = 1;
        serve(5, ct, 20, 1, 0);
        checks++; if (o_hold_seen !== 20 || o_unstable !== 0) begin failures++; $display("FAIL hold_stable held=%0d unstable=%0d want held=20 unstable=0", o_hold_seen, o_unstable); end
        checks++; if (o_rsp_data !== ct || o_rsp_err !== 1'b0 || o_valid_after !== 1'b0) begin failures++; $display("FAIL hold_rsp data=%h err=%b after=%b want data=%h err=0 after=0", o_rsp_data, o_rsp_err, o_valid_after, ct); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int n;
        logic [127:0] ct;
        data1 = rand128(); key1 = rand256(); mode1 = 2'd2; req1 = 1;
        seen = 0; n = 0;
        while (!seen && n < 20) begin
            @(negedge clk); n++;
            if (gnt1) req1 = 0;
            if (core_start) seen = 1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL mid_start got=0 want=1"); end
        repeat (5) @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks++; if ({gnt0, gnt1, core_start, rsp_valid0, rsp_valid1, rsp_err} !== 6'b0 || core_in !== '0 || core_key !== '0 || core_mode !== '0 || rsp_data !== '0) begin failures++; $display("FAIL mid_reset_outputs ctrl=%b in=%h want all 0", {gnt0, gnt1, core_start, rsp_valid0, rsp_valid1, rsp_err}, core_in); end
        @(negedge clk) rst_n = 1;
        n = 0;
        repeat (3) begin @(negedge clk); if (rsp_valid0 || rsp_valid1) n++; end
        checks++; if (n !== 0) begin failures++; $display("FAIL mid_no_rsp got=%0d want=0", n); end
        ct = rand128(); data1 = rand128(); mode1 = 2'd1; req1 = 1;
        serve(4, ct, 1, 0, 0);
        checks++; if (o_gnt_id !== 1 || o_gnt_cyc !== 1 || o_rsp_cyc !== 6 || o_rsp_data !== ct || o_rsp_err !== 1'b0) begin failures++; $display("FAIL mid_fresh gnt=%0d cyc=%0d rcyc=%0d err=%b want gnt=1 cyc=1 rcyc=6 err=0", o_gnt_id, o_gnt_cyc, o_rsp_cyc, o_rsp_err); end
    endtask

    // Reference: pending requests per requester, round robin via last winner,
    // response timing/content from the delay the core model chooses.
    task automatic test_random();
        bit           pend[2];
        logic [127:0] pdata[2];
        logic [255:0] pkey[2];
        logic [1:0]   pmode[2];
        int           lw, w, d, hold, exp_cyc;
        bit           exp_err;
        logic [127:0] ct, exp_data;
        @(negedge clk) rst_n = 0;
        @(negedge clk) rst_n = 1;
        lw = 1; pend[0] = 0; pend[1] = 0;
        for (int it = 0; it < 14; it++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1 || (!pend[0] && !pend[1] && i == 1))) begin
                    pend[i] = 1; pdata[i] = rand128(); pkey[i] = rand256();
                    pmode[i] = 2'($urandom_range(0, 3));
                end
            end
            req0 = pend[0]; data0 = pdata[0]; key0 = pkey[0]; mode0 = pmode[0];
            req1 = pend[1]; data1 = pdata[1]; key1 = pkey[1]; mode1 = pmode[1];
            w = (pend[0] && pend[1]) ? 1 - lw : (pend[1] ? 1 : 0);
            d = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO + 3));
            hold = $urandom_range(0, 3);
            ct = rand128();
            exp_err  = (pmode[w] == 2'd0) || !(d >= 1 && d <= TO);
            exp_data = exp_err ? 128'd0 : ct;
            exp_cyc  = (pmode[w] == 2'd0) ? 2 : 2 + ((d >= 1 && d <= TO) ? d : TO);
            serve(d, ct, hold, $urandom_range(0, 1) == 1, 0);
            checks++; if (o_gnt_id !== w || o_gnt_cnt !== 1 || o_gnt_cyc !== 1) begin failures++; $display("FAIL rnd_gnt[%0d] id=%0d n=%0d cyc=%0d want id=%0d n=1 cyc=1", it, o_gnt_id, o_gnt_cnt, o_gnt_cyc, w); end
            checks++; if (o_core_in !== pdata[w] || o_core_key !== pkey[w] || o_core_mode !== pmode[w]) begin failures++; $display("FAIL rnd_operands[%0d] in=%h mode=%0d want in=%h mode=%0d", it, o_core_in, o_core_mode, pdata[w], pmode[w]); end
            checks++; if (o_start_cnt !== ((pmode[w] != 2'd0) ? 1 : 0)) begin failures++; $display("FAIL rnd_start[%0d] got=%0d mode=%0d", it, o_start_cnt, pmode[w]); end
            checks++; if (o_rsp_id !== w || o_rsp_cyc !== exp_cyc) begin failures++; $display("FAIL rnd_rsp_timing[%0d] id=%0d cyc=%0d want id=%0d cyc=%0d", it, o_rsp_id, o_rsp_cyc, w, exp_cyc); end
            checks++; if (o_rsp_err !== exp_err || o_rsp_data !== exp_data || o_unstable !== 0 || o_valid_after !== 1'b0) begin failures++; $display("FAIL rnd_rsp[%0d] err=%b data=%h unstable=%0d want err=%b data=%h", it, o_rsp_err, o_rsp_data, o_unstable, exp_err, exp_data); end
            pend[w] = 0; lw = w;
        end
        req0 = 0; req1 = 0;
    endtask

    initial begin
        test_reset();
        test_vector();
        test_rr_alternate();
        test_illegal_mode();
        test_timeout();
        test_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
